// File: rtl/mem_stage_lsu_if.sv
// Bus between the MEM-stage load/store unit and a single data-memory responder.
// The LSU drives the request side; the responder returns completion and read data.
interface mem_stage_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_be,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_be,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns one pipeline memory access into a single bus
// transaction, stalling the EX/MEM register until the response (or a timeout) is in.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_valid,
    input  logic [31:0]            mem_alu_dout,
    input  logic [31:0]            mem_mux_out_rf_dout_rs2,
    input  logic [2:0]             mem_dm_func,
    input  logic                   mem_dm_we,
    input  logic [1:0]             mem_rf_din_sel,
    output logic [31:0]            mem_dm_dout,
    output logic                   mem_stall,
    output logic                   mem_misalign,
    output logic                   mem_bus_err,
    mem_stage_lsu_if.master        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    // Access size code: 0 byte, 1 half, 2 word (reserved encodings behave as word)
    function automatic logic [1:0] size_of(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: size_of = 2'd0;
            3'b001, 3'b101: size_of = 2'd1;
            default:        size_of = 2'd2;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'd0:    is_aligned = 1'b1;
            2'd1:    is_aligned = ~a[0];
            default: is_aligned = (a == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'd0:    byte_en = 4'b0001 << a;
            2'd1:    byte_en = a[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'd0:    lane_wdata = {4{d[7:0]}};
            2'd1:    lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f, input logic [1:0] lane,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (f)
            3'b000:  load_fmt = {{24{b[7]}}, b};
            3'b100:  load_fmt = {24'h00_0000, b};
            3'b001:  load_fmt = {{16{h[15]}}, h};
            3'b101:  load_fmt = {16'h0000, h};
            default: load_fmt = rd;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [2:0]  func_q, func_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] dout_q, dout_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic        access_s;
    logic        aligned_s;
    logic [1:0]  size_s;

    assign access_s  = mem_valid & (mem_dm_we | (mem_rf_din_sel == 2'b01));
    assign size_s    = size_of(mem_dm_func);
    assign aligned_s = is_aligned(size_s, mem_alu_dout[1:0]);

    // Stall is combinational so the EX/MEM register is frozen in the same cycle the access is seen
    assign mem_stall = ((state_q == ST_IDLE) & access_s & aligned_s) | (state_q == ST_REQ);

    // Next-state, request capture, timeout counting and load-data formatting
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = 1'b0;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        func_d      = func_q;
        lane_d      = lane_q;
        dout_d      = dout_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_s && aligned_s) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_dm_we;
                    bus_addr_d  = {mem_alu_dout[31:2], 2'b00};
                    bus_wdata_d = lane_wdata(size_s, mem_mux_out_rf_dout_rs2);
                    bus_be_d    = byte_en(size_s, mem_alu_dout[1:0]);
                    func_d      = mem_dm_func;
                    lane_d      = mem_alu_dout[1:0];
                    cnt_d       = 10'd0;
                    state_d     = ST_REQ;
                end else if (access_s) begin
                    misalign_d  = 1'b1;
                    dout_d      = 32'h0000_0000;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.bus_ack) begin
                    if (!bus_we_q) begin
                        dout_d = load_fmt(func_q, lane_q, bus.bus_rdata);
                    end else begin
                        dout_d = dout_q;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    bus_err_d = 1'b1;
                    dout_d    = 32'h0000_0000;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d     = cnt_q + 10'd1;
                    bus_req_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 10'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wdata_q <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            func_q      <= 3'b000;
            lane_q      <= 2'b00;
            dout_q      <= 32'h0000_0000;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            func_q      <= func_d;
            lane_q      <= lane_d;
            dout_q      <= dout_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_be    = bus_be_q;
    assign mem_dm_dout   = dout_q;
    assign mem_misalign  = misalign_q;
    assign mem_bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios then randomized accesses,
// each compared against a size/offset arithmetic model of the load/store rules.
module tb_mem_stage_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_alu_dout;
    logic [31:0] mem_mux_out_rf_dout_rs2;
    logic [2:0]  mem_dm_func;
    logic        mem_dm_we;
    logic [1:0]  mem_rf_din_sel;
    logic [31:0] mem_dm_dout;
    logic        mem_stall;
    logic        mem_misalign;
    logic        mem_bus_err;

    mem_stage_lsu_if bus_if ();

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk                     (clk),
        .rst                     (rst),
        .mem_valid               (mem_valid),
        .mem_alu_dout            (mem_alu_dout),
        .mem_mux_out_rf_dout_rs2 (mem_mux_out_rf_dout_rs2),
        .mem_dm_func             (mem_dm_func),
        .mem_dm_we               (mem_dm_we),
        .mem_rf_din_sel          (mem_rf_din_sel),
        .mem_dm_dout             (mem_dm_dout),
        .mem_stall               (mem_stall),
        .mem_misalign            (mem_misalign),
        .mem_bus_err             (mem_bus_err),
        .bus                     (bus_if)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f);
        if (f == 3'b000 || f == 3'b100) return 1;
        if (f == 3'b001 || f == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] rd);
        int          sz;
        logic [31:0] mask;
        logic [31:0] v;
        sz = size_bytes(f);
        if (sz == 4) return rd;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = (rd >> (8 * (a % 4))) & mask;
        if (!f[2] && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_bus_req"}, 32'(bus_if.bus_req), 32'd0);
        check({tag, "_err"}, 32'(mem_bus_err), 32'd0);
        check({tag, "_dout"}, mem_dm_dout, model_dout);
    endtask

    // One access from presentation until the pipeline advances. wait_n<0 means never ack.
    task automatic access(input logic [2:0] f, input logic we, input logic [1:0] sel,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input int wait_n, input logic [31:0] rd);
        int          sz;
        logic        aligned;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          req_n;
        int          exp_req;
        logic        done;
        sz      = size_bytes(f);
        aligned = ((addr % sz) == 0);
        exp_be  = 4'(((1 << sz) - 1) << (addr % 4));
        exp_wd  = (sz == 1) ? rs2[7:0] * 32'h0101_0101 :
                  (sz == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
        @(negedge clk);
        mem_valid = 1'b1; mem_dm_func = f; mem_dm_we = we; mem_rf_din_sel = sel;
        mem_alu_dout = addr; mem_mux_out_rf_dout_rs2 = rs2;
        bus_if.bus_ack = 1'b0;
        #1;
        check("stall_idle", 32'(mem_stall), 32'(aligned));
        if (!aligned) begin
            model_dout = 32'h0;
            @(negedge clk);
            check("misalign_pulse", 32'(mem_misalign), 32'd1);
            check("misalign_noreq", 32'(bus_if.bus_req), 32'd0);
            check("misalign_dout", mem_dm_dout, model_dout);
            mem_valid = 1'b0;
            @(negedge clk);
            check("misalign_end", 32'(mem_misalign), 32'd0);
            check("misalign_noreq2", 32'(bus_if.bus_req), 32'd0);
            return;
        end
        req_n = 0;
        done  = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (bus_if.bus_req === 1'b1) begin
                req_n++;
                check("bus_addr", bus_if.bus_addr, {addr[31:2], 2'b00});
                check("bus_be", 32'(bus_if.bus_be), 32'(exp_be));
                check("bus_we", 32'(bus_if.bus_we), 32'(we));
                if (we) check("bus_wdata", bus_if.bus_wdata, exp_wd);
                check("stall_req", 32'(mem_stall), 32'd1);
                check("err_in_req", 32'(mem_bus_err), 32'd0);
                if (wait_n >= 0 && req_n - 1 == wait_n) begin
                    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rd;
                end else begin
                    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom;
                end
            end else begin
                done = 1'b1;
            end
        end
        exp_req = (wait_n < 0) ? TO : wait_n + 1;
        check("req_cycles", 32'(req_n), 32'(exp_req));
        if (wait_n < 0) model_dout = 32'h0;
        else if (!we) model_dout = exp_load(f, addr, rd);
        check("done_stall", 32'(mem_stall), 32'd0);
        check("done_err", 32'(mem_bus_err), 32'(wait_n < 0));
        check("done_dout", mem_dm_dout, model_dout);
        // Stray ack during DONE, with the access still presented, must not restart anything
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = $urandom;
        @(negedge clk);
        mem_valid = 1'b0; bus_if.bus_ack = 1'b0;
        check_idle_outputs("after_done");
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; mem_alu_dout = 32'h0; mem_mux_out_rf_dout_rs2 = 32'h0;
        mem_dm_func = 3'b000; mem_dm_we = 1'b0; mem_rf_din_sel = 2'b00;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
        model_dout = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_bus_addr", bus_if.bus_addr, 32'h0);
        check("rst_bus_be", 32'(bus_if.bus_be), 32'h0);
        check("rst_misalign", 32'(mem_misalign), 32'd0);
        check_idle_outputs("rst");
        rst = 1'b0; bus_if.bus_ack = 1'b0;

        access(3'b000, 1'b0, 2'b01, 32'h0000_1003, 32'h0, 0, 32'h80FF_0000);
        check("lb_value", mem_dm_dout, 32'hFFFF_FF80);
        access(3'b001, 1'b1, 2'b00, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h5555_5555);
        check("sh_keeps_dout", mem_dm_dout, 32'hFFFF_FF80);
        access(3'b010, 1'b0, 2'b01, 32'h0000_3001, 32'h0, 0, 32'h0);
        access(3'b000, 1'b0, 2'b01, 32'h0000_0001, 32'h0, 1, 32'h0000_7F00);
        access(3'b101, 1'b0, 2'b01, 32'h0000_4002, 32'h0, -1, 32'h0);

        // Reset in the second REQ cycle of a word load, then a late ack
        @(negedge clk);
        mem_valid = 1'b1; mem_dm_func = 3'b010; mem_dm_we = 1'b0; mem_rf_din_sel = 2'b01;
        mem_alu_dout = 32'h0000_5000;
        @(negedge clk);
        check("rstreq_req1", 32'(bus_if.bus_req), 32'd1);
        @(negedge clk);
        check("rstreq_req2", 32'(bus_if.bus_req), 32'd1);
        rst = 1'b1; mem_valid = 1'b0;
        @(negedge clk);
        model_dout = 32'h0;
        check("rstreq_addr", bus_if.bus_addr, 32'h0);
        check("rstreq_we", 32'(bus_if.bus_we), 32'd0);
        check_idle_outputs("rstreq");
        rst = 1'b0; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        check_idle_outputs("late_ack");
        access(3'b010, 1'b0, 2'b01, 32'h0000_5000, 32'h0, 0, 32'hCAFE_F00D);
        check("lw_after_rst", mem_dm_dout, 32'hCAFE_F00D);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic        we;
            logic [1:0]  sel;
            logic [31:0] a;
            int          w;
            f   = 3'($urandom_range(0, 7));
            we  = 1'($urandom_range(0, 1));
            sel = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
            if (!we && sel != 2'b01) sel = 2'b01;
            a   = $urandom;
            w   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 3));
            if (i % 7 == 3) begin
                // Non-access cycles, with stray ack, must leave everything idle
                @(negedge clk);
                mem_valid = 1'(i % 2); mem_dm_we = 1'b0; mem_rf_din_sel = 2'b10;
                bus_if.bus_ack = 1'b1; bus_if.bus_rdata = $urandom;
                #1;
                check("noacc_stall", 32'(mem_stall), 32'd0);
                @(negedge clk);
                mem_valid = 1'b0; bus_if.bus_ack = 1'b0;
                check_idle_outputs("noacc");
            end
            access(f, we, sel, a, $urandom, w, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
